// File: rtl/key_scan_multi_if.sv
// Key pins in, debounced level and per-key event strobes out.
// valid/ready is not used: every strobe is a single-cycle event with no back-pressure.
interface key_scan_multi_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;
  logic [N_KEYS-1:0] repeat_pulse;

  modport master (
    output key_in,
    input  key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  key_in,
    output key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/key_scan_multi.sv
// Multi-channel key debouncer with press/release, long-press and auto-repeat strobes.
// Each channel: 2-flop sync -> polarity sample flop -> debounce counter -> hold counter.
module key_scan_multi #(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 500_000,
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  key_scan_multi_if.slave       bus
);

  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + REPEAT_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG_M1 = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG    = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_WRAP    = HOLD_W'(LONG_CYCLES + REPEAT_CYCLES - 1);

  // Synchronisers reset to the pin level of a released key.
  localparam logic [N_KEYS-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] samp_q, samp_d;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic [N_KEYS-1:0] repeat_q, repeat_d;
  logic [DEB_W-1:0]  deb_cnt_q [N_KEYS];
  logic [DEB_W-1:0]  deb_cnt_d [N_KEYS];
  logic [HOLD_W-1:0] hold_cnt_q [N_KEYS];
  logic [HOLD_W-1:0] hold_cnt_d [N_KEYS];

  always_comb begin
    sync1_d   = bus.key_in;
    sync2_d   = sync1_q;
    samp_d    = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      deb_cnt_d[i]  = '0;
      hold_cnt_d[i] = '0;
      if (samp_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];
      // Hold events need the key to stay pressed across this edge, so a
      // release coinciding with a long/repeat slot suppresses it.
      if (level_q[i] && level_d[i]) begin
        long_d[i]     = (hold_cnt_q[i] == HOLD_LONG_M1);
        repeat_d[i]   = (hold_cnt_q[i] == HOLD_WRAP);
        hold_cnt_d[i] = repeat_d[i] ? HOLD_LONG : hold_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= IDLE_PIN;
      sync2_q   <= IDLE_PIN;
      samp_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      samp_q    <= samp_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < N_KEYS; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign bus.key_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_scan_multi.sv
// Directed bench for key_scan_multi (4 keys, DEB=4, LONG=20, REPEAT=8, active-low pins).
// Cycle count c=1 is the first edge that samples a new pin level; accepted events land at c=7.
module tb_key_scan_multi;
  localparam int N_KEYS = 4;
  localparam int DEB    = 4;
  localparam int LONG   = 20;
  localparam int REP    = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  key_scan_multi_if #(.N_KEYS(N_KEYS)) bus ();

  key_scan_multi #(
    .N_KEYS(N_KEYS), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check_idle(input string tag);
    check(tag, {12'd0, bus.key_level, bus.press_pulse, bus.release_pulse,
                bus.long_pulse, bus.repeat_pulse}, 32'd0);
  endtask

  task automatic settle(input string tag);
    bus.key_in = 4'hF;
    ticks(12);
    check_idle(tag);
  endtask

  logic seen;

  initial begin
    rst        = 1'b1;
    bus.key_in = 4'hF;
    #1;
    check_idle("reset_async");
    ticks(2);
    check_idle("reset_held");
    rst = 1'b0;
    ticks(12);
    check_idle("post_reset_idle");

    // single press on key 0
    bus.key_in[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check($sformatf("k0_press c%0d", c), {28'd0, bus.press_pulse}, (c == 7) ? 32'h1 : 32'h0);
      check($sformatf("k0_level c%0d", c), {28'd0, bus.key_level}, (c >= 7) ? 32'h1 : 32'h0);
    end
    settle("k0_settle");

    // glitch train on key 1: 3 low, 1 high
    seen = 1'b0;
    for (int r = 0; r < 6; r++) begin
      bus.key_in[1] = 1'b0;
      for (int t = 0; t < 3; t++) begin
        tick();
        seen = seen | bus.key_level[1] | bus.press_pulse[1] | bus.release_pulse[1];
      end
      bus.key_in[1] = 1'b1;
      tick();
      seen = seen | bus.key_level[1] | bus.press_pulse[1] | bus.release_pulse[1];
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      seen = seen | bus.key_level[1] | bus.press_pulse[1] | bus.release_pulse[1];
    end
    check("k1_glitch_reject", {31'd0, seen}, 32'd0);

    // long press with repeats on key 2, released after 40 held cycles
    bus.key_in[2] = 1'b0;
    ticks(6);
    tick();
    check("k2_press", {28'd0, bus.press_pulse}, 32'h4);
    for (int k = 1; k <= 47; k++) begin
      tick();
      check($sformatf("k2_events k%0d", k),
            {29'd0, bus.long_pulse[2], bus.repeat_pulse[2], bus.release_pulse[2]},
            {29'd0, 1'(k == 20), 1'(k == 28 || k == 36 || k == 44), 1'(k == 47)});
      if (k == 40) bus.key_in[2] = 1'b1;
    end
    check("k2_level_after", {28'd0, bus.key_level}, 32'h0);
    settle("k2_settle");

    // short press on key 3: no long/repeat
    bus.key_in[3] = 1'b0;
    ticks(6);
    tick();
    check("k3_press", {28'd0, bus.press_pulse}, 32'h8);
    for (int k = 1; k <= 25; k++) begin
      tick();
      check($sformatf("k3_events k%0d", k),
            {28'd0, bus.press_pulse[3], bus.long_pulse[3], bus.repeat_pulse[3], bus.release_pulse[3]},
            {31'd0, 1'(k == 17)});
      if (k == 10) bus.key_in[3] = 1'b1;
    end
    settle("k3_settle");

    // all keys at once
    bus.key_in = 4'h0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("all_press c%0d", c), {28'd0, bus.press_pulse}, (c == 7) ? 32'hF : 32'h0);
    end
    settle("all_settle");

    // reset mid-hold on key 0
    bus.key_in[0] = 1'b0;
    ticks(6);
    tick();
    check("k0r_press", {28'd0, bus.press_pulse}, 32'h1);
    ticks(15);
    rst = 1'b1;
    #1;
    check_idle("k0r_async_reset");
    tick();
    check_idle("k0r_reset_held");
    rst = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      check($sformatf("k0r_events c%0d", c),
            {28'd0, bus.press_pulse[0], bus.long_pulse[0], bus.repeat_pulse[0], bus.release_pulse[0]},
            {28'd0, 1'(c == 7), 1'(c == 27), 2'b00});
    end
    settle("k0r_settle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
